// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: divides the board clock into main_clk and gates it under run/step control.
// A step emits exactly two main_clk periods (one CPU cycle); main_clk only starts and stops while low.
module cpu_clock_ctrl #(
    parameter int DIV_HALF     = 4,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    output logic             main_clk,
    output logic             running,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int               DIV_W        = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int               DB_W         = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV_HALF - 1);
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [2:0]       STEP_TOGGLES = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic r_run_meta;
    logic r_run_s;
    logic r_btn_meta;
    logic r_btn_s;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its source, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_run_meta <= run_sw;
            r_run_s    <= r_run_meta;
            r_btn_meta <= step_btn;
            r_btn_s    <= r_btn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Step button debounce
    // ------------------------------------------------------------------
    logic [DB_W-1:0] r_db_cnt;
    logic            r_db_stable;
    logic            r_step_pulse;
    logic            w_db_accept;

    // The counter only advances while the sampled level disagrees with the stable one.
    assign w_db_accept = (r_btn_s != r_db_stable) && (r_db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_cnt     <= '0;
            r_db_stable  <= 1'b0;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_pulse <= w_db_accept && r_btn_s;
            if (r_btn_s == r_db_stable) begin
                r_db_cnt <= '0;
            end else if (w_db_accept) begin
                r_db_cnt    <= '0;
                r_db_stable <= r_btn_s;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Run/step FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_toggles_left;
    logic [2:0]       w_next_toggles;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_main_clk;
    logic             r_running;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             w_tick;
    logic             w_rise;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state   = r_state;
        w_next_toggles = r_toggles_left;
        w_tick         = (r_state != ST_IDLE) && (r_div_cnt == DIV_LAST);
        w_rise         = w_tick && !r_main_clk;

        case (r_state)
            ST_IDLE: begin
                if (r_run_s) begin
                    w_next_state = ST_RUN;
                end else if (r_step_pulse) begin
                    w_next_state   = ST_STEP;
                    w_next_toggles = STEP_TOGGLES;
                end
            end
            ST_RUN: begin
                // Stop only on the toggle that brings main_clk low: no runt high phase.
                if (w_tick && r_main_clk && !r_run_s) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (w_tick) begin
                    w_next_toggles = r_toggles_left - 3'd1;
                    if (r_toggles_left == 3'd1) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_toggles_left <= 3'd0;
            r_running      <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_toggles_left <= w_next_toggles;
            r_running      <= (w_next_state != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Divider, gated clock and rising-edge counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_main_clk <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_div_cnt  <= '0;
                r_main_clk <= 1'b0;
            end else if (w_tick) begin
                r_div_cnt  <= '0;
                r_main_clk <= ~r_main_clk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            if (w_rise) begin
                r_edge_cnt <= r_edge_cnt + CNT_W'(1);
            end
        end
    end

    assign main_clk = r_main_clk;
    assign running  = r_running;
    assign edge_cnt = r_edge_cnt;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: directed run/step/bounce/overlap/reset sequence for cpu_clock_ctrl.
// Expected main_clk edges are queued with their clk cycle when stimulus is driven and popped as they appear.
module tb_cpu_clock_ctrl;

    localparam int DIV_HALF = 4;
    localparam int DB       = 8;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             run_sw;
    logic             step_btn;
    logic             main_clk;
    logic             running;
    logic [CNT_W-1:0] edge_cnt;

    typedef struct {
        int   cyc;
        logic lvl;
    } ev_t;

    ev_t  sb[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   exp_edges = 0;
    bit   mon_en    = 1'b1;
    logic prev_mc   = 1'b0;

    cpu_clock_ctrl #(
        .DIV_HALF    (DIV_HALF),
        .DEBOUNCE_CYC(DB),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run_sw  (run_sw),
        .step_btn(step_btn),
        .main_clk(main_clk),
        .running (running),
        .edge_cnt(edge_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_ev(input int c, input logic l);
        ev_t e;
        e.cyc = c;
        e.lvl = l;
        sb.push_back(e);
    endtask

    // Free run entered at exit_c; run_sw dropped at drop_c becomes visible to the FSM
    // three edges later (two sync stages plus the registered decision).
    task automatic push_run(input int exit_c, input int drop_c, output int end_c);
        int r;
        r     = exit_c + DIV_HALF;
        end_c = 0;
        for (int k = 0; k < 1000; k++) begin
            push_ev(r, 1'b1);
            exp_edges++;
            push_ev(r + DIV_HALF, 1'b0);
            if (r + DIV_HALF >= drop_c + 3) begin
                end_c = r + DIV_HALF;
                break;
            end
            r += 2 * DIV_HALF;
        end
    endtask

    task automatic push_step(input int exit_c, output int end_c);
        push_ev(exit_c + DIV_HALF, 1'b1);
        push_ev(exit_c + 2 * DIV_HALF, 1'b0);
        push_ev(exit_c + 3 * DIV_HALF, 1'b1);
        push_ev(exit_c + 4 * DIV_HALF, 1'b0);
        exp_edges += 2;
        end_c = exit_c + 4 * DIV_HALF;
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        if (reset || !mon_en) begin
            prev_mc = main_clk;
        end else if (main_clk !== prev_mc) begin
            prev_mc = main_clk;
            if (sb.size() == 0) begin
                check("edge_expected", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("edge_cycle", cyc, e.cyc);
                check("edge_level", main_clk, e.lvl);
            end
        end
    end

    initial begin
        int c;
        int ex;
        int e_end;
        int r_end;

        reset    = 1'b1;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_main_clk", main_clk, 0);
        check("rst_running", running, 0);
        check("rst_edge_cnt", edge_cnt, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Free run for 80 clk, dropped while main_clk is high.
        c = cyc;
        push_run(c + 3, c + 80, e_end);
        run_sw = 1'b1;
        wait_cyc(c + 2);
        check("run_idle_before_exit", running, 0);
        wait_cyc(c + 3);
        check("run_running", running, 1);
        wait_cyc(c + 80);
        check("run_drop_while_high", main_clk, 1);
        run_sw = 1'b0;
        wait_cyc(e_end - 1);
        check("run_still_running", running, 1);
        wait_cyc(e_end);
        check("run_stopped", running, 0);
        check("run_ends_low", main_clk, 0);
        repeat (10) @(negedge clk);
        check("run_edge_cnt", edge_cnt, exp_edges);
        check("run_sb_empty", sb.size(), 0);

        // Free run dropped while main_clk is low.
        c = cyc;
        push_run(c + 3, c + 60, e_end);
        run_sw = 1'b1;
        wait_cyc(c + 60);
        check("run2_drop_while_low", main_clk, 0);
        run_sw = 1'b0;
        wait_cyc(e_end);
        check("run2_stopped", running, 0);
        repeat (10) @(negedge clk);
        check("run2_edge_cnt", edge_cnt, exp_edges);

        // Clean step press.
        c  = cyc;
        ex = c + 3 + DB;
        push_step(ex, e_end);
        step_btn = 1'b1;
        wait_cyc(ex - 1);
        check("step_idle_before", running, 0);
        wait_cyc(ex);
        check("step_running", running, 1);
        wait_cyc(e_end - 1);
        check("step_still_running", running, 1);
        wait_cyc(e_end);
        check("step_done", running, 0);
        check("step_ends_low", main_clk, 0);
        step_btn = 1'b0;
        repeat (20) @(negedge clk);
        check("step_edge_cnt", edge_cnt, exp_edges);
        check("step_sb_empty", sb.size(), 0);

        // Bouncing button, then held.
        c = cyc;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(c + 3 * i);
            step_btn = ~step_btn;
        end
        wait_cyc(c + 30);
        check("bounce_no_run", running, 0);
        check("bounce_edge_cnt", edge_cnt, exp_edges);
        c  = cyc;
        ex = c + 3 + DB;
        push_step(ex, e_end);
        step_btn = 1'b1;
        wait_cyc(e_end);
        check("bounce_step_done", running, 0);
        step_btn = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_edge_cnt_after", edge_cnt, exp_edges);
        check("bounce_sb_empty", sb.size(), 0);

        // Step press during RUN is dropped.
        c = cyc;
        push_run(c + 3, c + 60, e_end);
        run_sw = 1'b1;
        wait_cyc(c + 10);
        step_btn = 1'b1;
        wait_cyc(c + 25);
        step_btn = 1'b0;
        wait_cyc(c + 60);
        run_sw = 1'b0;
        wait_cyc(e_end);
        check("ovl_run_stopped", running, 0);
        repeat (20) @(negedge clk);
        check("ovl_run_edge_cnt", edge_cnt, exp_edges);
        check("ovl_run_sb_empty", sb.size(), 0);

        // run_sw rising during STEP waits for the 4th toggle.
        c  = cyc;
        ex = c + 3 + DB;
        push_step(ex, e_end);
        step_btn = 1'b1;
        wait_cyc(ex + 2);
        push_run(e_end + 1, e_end + 40, r_end);
        run_sw = 1'b1;
        wait_cyc(e_end);
        check("ovl_step_idle_gap", running, 0);
        check("ovl_step_low", main_clk, 0);
        wait_cyc(e_end + 1);
        check("ovl_run_after_step", running, 1);
        wait_cyc(e_end + 5);
        step_btn = 1'b0;
        wait_cyc(e_end + 40);
        run_sw = 1'b0;
        wait_cyc(r_end);
        check("ovl_final_stop", running, 0);
        repeat (10) @(negedge clk);
        check("ovl_edge_cnt", edge_cnt, exp_edges);
        check("ovl_sb_empty", sb.size(), 0);

        // Asynchronous reset while main_clk is high.
        mon_en = 1'b0;
        sb.delete();
        run_sw = 1'b1;
        for (int k = 0; k < 40 && main_clk !== 1'b1; k++) @(negedge clk);
        check("t1_high_before", main_clk, 1);
        check("t1_running_before", running, 1);
        check("t1_edge_before", edge_cnt, exp_edges + 1);
        #1 reset = 1'b1;
        #1;
        check("t1_main_clk", main_clk, 0);
        check("t1_running", running, 0);
        check("t1_edge_cnt", edge_cnt, 0);
        run_sw = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t1_post_running", running, 0);
        check("t1_post_main_clk", main_clk, 0);
        check("t1_post_edge_cnt", edge_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
